data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning stall cycles per access when wait states are compiled in; legal range 0..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port data_sram_en  input  1  access request from the CPU data port.
REQ-006 SHALL have port data_sram_wen  input  4  byte write enables; nonzero with en means write, zero with en means read.
REQ-007 SHALL have port data_sram_addr  input  32  byte address.
REQ-008 SHALL have port data_sram_wdata  input  32  write data.
REQ-009 SHALL have port data_sram_rdata  output  32  registered read data returned to the memory stage.
REQ-010 SHALL have port stall_req  output  1  request to the stall controller to hold the pipeline.

Function
REQ-011 SHALL index memory by word = data_sram_addr[ADDR_BITS+1:2]; addr[1:0] and bits above ADDR_BITS+1 are ignored, so out-of-range addresses wrap.
REQ-012 SHALL accept an access on a rising edge when data_sram_en=1 and the block is idle.
REQ-013 SHALL commit an accepted write on its acceptance edge, with wen[i] writing bits 8i+7:8i only and other lanes unchanged.
REQ-014 SHALL sample memory for an accepted read on its acceptance edge, returning the full word regardless of addr[1:0].
REQ-015 SHALL leave data_sram_rdata unchanged on writes, idle cycles (en=0) and ignored requests.
REQ-016 SHALL return new data on a read to the same word issued on the edge after a write.
REQ-017 SHALL, without wait states (see Configuration), present read data on rdata one cycle after acceptance, hold it until the next accepted read, and keep stall_req=0.
REQ-018 SHALL, with wait states, implement FSM IDLE/BUSY: IDLE->BUSY on acceptance when WAIT_CYCLES>0, loading a 4-bit counter with WAIT_CYCLES; counter decrements each BUSY cycle; BUSY->IDLE on the edge where the counter is 1.
REQ-019 SHALL, with wait states, drive stall_req=1 exactly while in BUSY (WAIT_CYCLES cycles per access), registered, not combinational from inputs.
REQ-020 SHALL, with wait states, hold the sampled read word in an internal register and load it onto rdata on the BUSY->IDLE edge, giving read latency WAIT_CYCLES+1.
REQ-021 SHALL ignore data_sram_en while in BUSY, with no memory or rdata effect.
REQ-022 SHALL behave exactly as REQ-017 when wait states are compiled in and WAIT_CYCLES=0, never entering BUSY.

Reset
REQ-023 SHALL, while rst=0, force rdata=0, stall_req=0, state IDLE, counter=0, and hold-register=0, independent of clk.
REQ-024 SHALL not alter memory contents on reset.
REQ-025 SHALL, on reset during BUSY, abort the access: pending read data is discarded; a write accepted before reset remains committed.
REQ-026 SHALL accept a request on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL compile wait-state logic (FSM, counter, hold register, nonzero stall_req) only when macro DATA_SRAM_WAIT_EN is defined.
REQ-028 SHALL, without DATA_SRAM_WAIT_EN, tie stall_req to 0, ignore WAIT_CYCLES, and provide single-cycle behaviour per REQ-017.

Verification
REQ-029 SHALL cover no-wait read: write 0x12345678 to 0x10, read 0x10 -> rdata=0x12345678 one cycle after the read edge, stall_req=0 throughout.
REQ-030 SHALL cover byte lanes: word 0x0 holds 0xAABBCCDD, write wen=4'b0101 wdata=0x11223344 -> read 0x0 returns 0xAA22CC44.
REQ-031 SHALL cover wrap: ADDR_BITS=10, write 0xCAFEF00D to 0x1004 -> read 0x0004 returns 0xCAFEF00D.
REQ-032 SHALL cover wait states (DATA_SRAM_WAIT_EN, WAIT_CYCLES=2): read 0x20 holding 0xDEADBEEF -> stall_req=1 for exactly 2 cycles, rdata=0xDEADBEEF on the edge stall_req falls, old rdata held until then; a request to 0x24 during BUSY has no effect.
REQ-033 SHALL cover reset mid-BUSY: assert rst=0 one cycle into a 2-wait read -> rdata=0 and stall_req=0 immediately, without a clk edge; a read of the same address after release returns the stored word.

Source files
------------

// File: rtl/data_sram_resp.sv
// data_sram_resp: synchronous word-addressed data SRAM answering the CPU data port.
//
// Writes commit on the acceptance edge with per-byte lane enables. Reads sample the
// array on the acceptance edge and return the full 32-bit word on a registered output.
//
// Optional wait states are compiled in with macro DATA_SRAM_WAIT_EN. When present, each
// accepted access (read or write) holds the block busy for WAIT_CYCLES cycles, stall_req
// is raised for exactly that time, and read data is released onto data_sram_rdata on the
// edge that leaves the busy state. Requests arriving while busy are dropped.
//
// Parameters:
//   ADDR_BITS   log2 of memory depth in 32-bit words
//   WAIT_CYCLES stall cycles per access with wait states compiled in (0..15)
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   data_sram_en    access request
//   data_sram_wen   byte write enables (nonzero = write, zero = read)
//   data_sram_addr  byte address (word index taken from bits ADDR_BITS+1:2, upper bits wrap)
//   data_sram_wdata write data
//   data_sram_rdata registered read data
//   stall_req       registered pipeline hold request
module data_sram_resp #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall_req
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  logic [31:0] mem [Depth];

  logic [ADDR_BITS-1:0] word_idx;
  logic                 is_write;
  logic                 accept;
  logic [31:0]          rdata_q;

  assign word_idx = data_sram_addr[ADDR_BITS+1:2];
  assign is_write = |data_sram_wen;

  // Byte offset and bits above the array depth are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_BITS+2], data_sram_addr[1:0]};

  // Memory array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;

`ifdef DATA_SRAM_WAIT_EN

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] rdata_d;

  assign accept = data_sram_en && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    rd_pend_d = rd_pend_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WaitLoad == 4'd0) begin
            // Zero wait states: behave as the single-cycle memory.
            if (!is_write) rdata_d = mem[word_idx];
          end else begin
            state_d   = StBusy;
            cnt_d     = WaitLoad;
            rd_pend_d = !is_write;
            if (!is_write) hold_d = mem[word_idx];
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = StIdle;
          rd_pend_d = 1'b0;
          // Only reads update rdata; a finished write leaves it alone.
          if (rd_pend_q) rdata_d = hold_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      hold_q    <= 32'd0;
      rd_pend_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
      rdata_q   <= rdata_d;
    end
  end

  assign stall_req = (state_q == StBusy);

`else

  // Without wait states the block is always idle and WAIT_CYCLES has no effect.
  logic unused_wait_cycles;
  assign unused_wait_cycles = ^WAIT_CYCLES;

  assign accept = data_sram_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else if (accept && !is_write) begin
      rdata_q <= mem[word_idx];
    end
  end

  assign stall_req = 1'b0;

`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed vector table, wait-state and reset
// sequences, and randomized traffic checked against a behavioural memory model.
module tb_data_sram_resp;

  localparam int unsigned AddrBits = 10;
`ifdef DATA_SRAM_WAIT_EN
  localparam int unsigned Waits = 2;
`else
  localparam int unsigned Waits = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;

  data_sram_resp #(
    .ADDR_BITS  (AddrBits),
    .WAIT_CYCLES(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_sram_en   (en),
    .data_sram_wen  (wen),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .stall_req      (stall)
  );

  always #5 clk = ~clk;

  // Behavioural model: word array, expected output word, remaining busy cycles.
  logic [31:0] ref_mem [1 << AddrBits];
  logic [31:0] exp_rdata;
  logic [31:0] pend_val;
  bit          pend_rd;
  int          busy_left;

  int total;
  int bad;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, want);
    end
  endtask

  function automatic logic [31:0] pre(input int w);
    logic [7:0] b;
    b = w[7:0];
    return {8'hA5, b, ~b, 8'h3C};
  endfunction

  // Applies the rules for one rising edge using the inputs the DUT sampled.
  function automatic void model_edge();
    int w;
    w = int'(addr[AddrBits+1:2]);
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0 && pend_rd) begin
        exp_rdata = pend_val;
        pend_rd   = 1'b0;
      end
    end else if (en) begin
      if (wen != 4'b0) begin
        for (int i = 0; i < 4; i++)
          if (wen[i]) ref_mem[w][8*i +: 8] = wdata[8*i +: 8];
      end else if (Waits == 0) begin
        exp_rdata = ref_mem[w];
      end else begin
        pend_val = ref_mem[w];
        pend_rd  = 1'b1;
      end
      busy_left = Waits;
    end
  endfunction

  function automatic void model_reset();
    exp_rdata = 32'd0;
    busy_left = 0;
    pend_rd   = 1'b0;
  endfunction

  task automatic drive(input logic e, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] d);
    en    = e;
    wen   = we;
    addr  = a;
    wdata = d;
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check({name, " rdata"}, rdata, exp_rdata);
    check({name, " stall"}, {31'd0, stall}, {31'd0, busy_left > 0});
  endtask

  // One access followed by enough idle cycles for it to complete.
  task automatic access(input string name, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] d);
    drive(1'b1, we, a, d);
    step(name);
    en = 1'b0;
    repeat (Waits) step(name);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    pend_val = 32'd0;

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000};
    tbl[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678};
    tbl[2]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
    tbl[3]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hAABB_CCDD, 32'h1234_5678};
    tbl[4]  = '{1'b1, 4'h5, 32'h0000_0000, 32'h1122_3344, 32'h1234_5678};
    tbl[5]  = '{1'b1, 4'h0, 32'h0000_0003, 32'h0000_0000, 32'hAA22_CC44};
    tbl[6]  = '{1'b1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D, 32'hAA22_CC44};
    tbl[7]  = '{1'b1, 4'h0, 32'h0000_0004, 32'h0000_0000, 32'hCAFE_F00D};
    tbl[8]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h5555_5555, 32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 4'h0, 32'h0000_0013, 32'h0000_0000, 32'h1234_5678};
    tbl[10] = '{1'b1, 4'h8, 32'h0000_0010, 32'h9900_0000, 32'h1234_5678};
    tbl[11] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h9934_5678};
    tbl[12] = '{1'b1, 4'h0, 32'hFFFF_F010, 32'h0000_0000, 32'h9934_5678};

    // Reset state.
    rst = 1'b0;
    drive(1'b0, 4'h0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset rdata", rdata, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    rst = 1'b1;

`ifndef DATA_SRAM_WAIT_EN
    // Directed single-cycle vectors; the first is accepted on the first edge after release.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d rdata", i), rdata, tbl[i].rdata);
      check($sformatf("vec%0d stall", i), {31'd0, stall}, 32'd0);
    end
`endif

    // Known contents for words 0..15.
    for (int w = 0; w < 16; w++) access("preload", 4'hF, 32'(w << 2), pre(w));

`ifdef DATA_SRAM_WAIT_EN
    // Wait-state read with a dropped request in the middle.
    access("ws_wr20", 4'hF, 32'h20, 32'hDEAD_BEEF);
    access("ws_wr24", 4'hF, 32'h24, 32'h0123_4567);
    access("ws_rd04", 4'h0, 32'h04, 32'd0);
    drive(1'b1, 4'h0, 32'h20, 32'd0);
    step("ws_e0");
    check("ws_e0 stall hi", {31'd0, stall}, 32'd1);
    check("ws_e0 old rdata", rdata, pre(1));
    drive(1'b1, 4'hF, 32'h24, 32'hBADB_AD00);
    step("ws_e1");
    check("ws_e1 stall hi", {31'd0, stall}, 32'd1);
    check("ws_e1 old rdata", rdata, pre(1));
    step("ws_e2");
    check("ws_e2 stall lo", {31'd0, stall}, 32'd0);
    check("ws_e2 rdata", rdata, 32'hDEAD_BEEF);
    en = 1'b0;
    step("ws_idle");
    access("ws_rd24", 4'h0, 32'h24, 32'd0);
    check("ws_24 intact", rdata, 32'h0123_4567);
`endif

    // Randomized traffic over words 0..15 with random upper and byte-offset bits.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      logic [31:0] a;
      r = $urandom;
      a = $urandom;
      drive(r[0], r[1] ? r[5:2] : 4'h0, {a[31:12], 6'd0, a[5:2], a[1:0]}, $urandom);
      step("rand");
    end
    en = 1'b0;
    repeat (Waits) step("rand_drain");

    // Asynchronous reset in the middle of an access.
    access("pre_rst", 4'h0, 32'h10, 32'd0);
    check("pre_rst rdata", rdata, ref_mem[4]);
    drive(1'b1, 4'h0, 32'h08, 32'd0);
    step("rst_acc");
    en = 1'b0;
    if (Waits > 0) step("rst_busy");
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("async rst rdata", rdata, 32'd0);
    check("async rst stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    check("held rst rdata", rdata, 32'd0);
    check("held rst stall", {31'd0, stall}, 32'd0);
    #2;
    rst = 1'b1;
    access("post_rst", 4'h0, 32'h08, 32'd0);
    check("post_rst word", rdata, ref_mem[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
